morse_char_sequencer: RTL
=========================

Name: morse_char_sequencer

Overview:
- Upstream feeder for the Morse signal stage.
- Accepts ASCII characters over a valid/ready handshake and converts each to a left-justified 5-bit dot/dash pattern plus a 3-bit length.
- Drives the signal stage's start/done handshake and inserts the inter-letter and inter-word silence the signal stage does not generate itself.

Parameters:
- UNIT_CYCLES, 6250000: clock cycles per Morse unit (250 ms at 25 MHz); must equal the signal stage's value.
- LETTER_GAP_EXTRA, 2: extra units of silence after each letter. The signal stage's trailing 1 unit plus these 2 give a 3-unit letter gap.
- WORD_GAP_EXTRA, 4: extra units of silence for a space character. Added on top of the preceding letter gap, this gives 7 units total.

Ports:
- i_Clock  in  1  system clock, rising edge
- i_Reset_n  in  1  asynchronous active-low reset
- i_Char  in  8  ASCII character
- i_Char_Valid  in  1  i_Char is valid
- o_Char_Ready  out  1  block can accept a character this cycle
- o_Start  out  1  start request to signal stage; held high until done is seen
- o_Morse_Pattern  out  5  symbols MSB-first, 0=dot, 1=dash, unused LSBs zero
- o_Morse_Length  out  3  symbol count, 1..5
- i_Done  in  1  done from signal stage
- o_Busy  out  1  high in every state except IDLE
- o_Char_Error  out  1  one-cycle pulse when an unsupported character is dropped

Behaviour:
- Clock and reset:
  - One clock, i_Clock.
  - Reset i_Reset_n is asynchronous, active-low.
  - While reset is asserted: state=IDLE, o_Start=0, o_Morse_Pattern=0, o_Morse_Length=0, o_Busy=0, o_Char_Error=0, o_Char_Ready=0, gap counter=0.
  - o_Char_Ready rises on the first clock edge after reset deasserts.
- Reset mid-operation aborts immediately. o_Start dropping low returns the signal stage to its own IDLE via its done/start rule.
- o_Char_Ready = 1 only in IDLE. A transfer happens on a cycle T with i_Char_Valid & o_Char_Ready; the character is registered at edge T.
- States:
  - IDLE: on a transfer, go to DECODE.
  - DECODE (1 cycle): table lookup, with lowercase a-z folded to A-Z.
    - Letter: register pattern and length, go to START.
    - Space (0x20): go to GAP with the word count.
    - Anything else: pulse o_Char_Error for 1 cycle and go to IDLE.
  - START: o_Start=1; pattern and length are stable and unchanged for the whole state. First o_Start=1 cycle is T+2. When i_Done=1 is sampled, go to RELEASE and clear o_Start next cycle.
  - RELEASE: o_Start=0; wait for i_Done=0, then go to GAP with the letter count.
  - GAP: count LETTER_GAP_EXTRA*UNIT_CYCLES or WORD_GAP_EXTRA*UNIT_CYCLES cycles, then go to IDLE. A zero-length gap goes to IDLE after 1 cycle.
- Gap counter width: $clog2(max(LETTER_GAP_EXTRA,WORD_GAP_EXTRA)*UNIT_CYCLES+1). Products are computed at full width with no truncation.
- Encoding examples: E=00000/1, T=10000/1, A=01000/2, N=10000/2, S=00000/3, O=11100/3, Q=11010/4, Y=10110/4.
- i_Char_Valid held high with no transfer possible has no effect; i_Char may change freely outside IDLE.
- i_Done high while in IDLE, DECODE or GAP is ignored.
- Consecutive spaces each add WORD_GAP_EXTRA units.

Optional Feature:
- Macro: MORSE_DIGITS_EN.
- Defined: digits '0'-'9' are encoded with length 5, e.g. 0=11111, 1=01111, 5=00000, 9=11110.
- Undefined: digits are unsupported (o_Char_Error pulse, dropped) and the lookup table holds letters only.

Test Plan:
- Reset/idle: with UNIT_CYCLES=4, assert i_Reset_n=0 mid-START -> o_Start=0, o_Busy=0, o_Char_Ready=0 immediately; o_Char_Ready=1 one edge after release.
- Single letter: 'A' accepted at T, signal stage model asserts i_Done 10 cycles after start -> o_Start=1 from T+2 with pattern=01000, length=2; o_Start low the cycle after i_Done; o_Char_Ready high exactly 8 cycles (2*4) after i_Done falls.
- Case folding and space: "s o" vs "S O" -> identical start sequences (00000/3, then 11100/3); 16 extra gap cycles before 'O' is accepted.
- Unsupported character: '#' (0x23) -> o_Char_Error high for exactly 1 cycle at T+1, no o_Start, back in IDLE at T+2.
- Backpressure: i_Char_Valid held high with stream "ET" -> second transfer occurs only after the first letter's GAP completes; 'T' drives 10000/1.
- Optional feature: '9' with MORSE_DIGITS_EN -> 11110/5; without it -> o_Char_Error pulse and no o_Start.

Source files
------------

// File: rtl/morse_char_sequencer.sv
// Morse character sequencer: ASCII in, pattern/length plus start/done to the signal stage.
// Optional MORSE_DIGITS_EN adds '0'-'9' to the lookup table.
module morse_char_sequencer #(
   parameter int unsigned UNIT_CYCLES      = 6250000,
   parameter int unsigned LETTER_GAP_EXTRA = 2,
   parameter int unsigned WORD_GAP_EXTRA   = 4
) (
   input  logic       i_Clock,
   input  logic       i_Reset_n,
   input  logic [7:0] i_Char,
   input  logic       i_Char_Valid,
   output logic       o_Char_Ready,
   output logic       o_Start,
   output logic [4:0] o_Morse_Pattern,
   output logic [2:0] o_Morse_Length,
   input  logic       i_Done,
   output logic       o_Busy,
   output logic       o_Char_Error
);

   localparam longint unsigned LetterCnt =
      64'(LETTER_GAP_EXTRA) * 64'(UNIT_CYCLES);
   localparam longint unsigned WordCnt =
      64'(WORD_GAP_EXTRA) * 64'(UNIT_CYCLES);
   localparam longint unsigned GapMax =
      (LetterCnt > WordCnt) ? LetterCnt : WordCnt;
   localparam int GW = (GapMax == 0) ? 1 : $clog2(GapMax + 1);

   // Counter is loaded with N-1 so GAP lasts N cycles, and 1 cycle when N=0
   localparam logic [GW-1:0] LetterLoad =
      (LetterCnt == 0) ? '0 : GW'(LetterCnt - 1);
   localparam logic [GW-1:0] WordLoad =
      (WordCnt == 0) ? '0 : GW'(WordCnt - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_START,
      S_RELEASE,
      S_GAP
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    char_q, char_d;
   logic [4:0]    pat_q, pat_d;
   logic [2:0]    len_q, len_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          rdy_q;

   logic [7:0]    up_char;
   logic          lut_hit;
   logic [4:0]    lut_pat;
   logic [2:0]    lut_len;
   logic          err;

   always_comb begin
      up_char = char_q;
      if (char_q >= "a" && char_q <= "z") begin
         up_char = char_q - 8'h20;
      end
   end

   always_comb begin
      lut_hit = 1'b1;
      lut_pat = '0;
      lut_len = '0;
      case (up_char)
         "A": begin lut_pat = 5'b01000; lut_len = 3'd2; end
         "B": begin lut_pat = 5'b10000; lut_len = 3'd4; end
         "C": begin lut_pat = 5'b10100; lut_len = 3'd4; end
         "D": begin lut_pat = 5'b10000; lut_len = 3'd3; end
         "E": begin lut_pat = 5'b00000; lut_len = 3'd1; end
         "F": begin lut_pat = 5'b00100; lut_len = 3'd4; end
         "G": begin lut_pat = 5'b11000; lut_len = 3'd3; end
         "H": begin lut_pat = 5'b00000; lut_len = 3'd4; end
         "I": begin lut_pat = 5'b00000; lut_len = 3'd2; end
         "J": begin lut_pat = 5'b01110; lut_len = 3'd4; end
         "K": begin lut_pat = 5'b10100; lut_len = 3'd3; end
         "L": begin lut_pat = 5'b01000; lut_len = 3'd4; end
         "M": begin lut_pat = 5'b11000; lut_len = 3'd2; end
         "N": begin lut_pat = 5'b10000; lut_len = 3'd2; end
         "O": begin lut_pat = 5'b11100; lut_len = 3'd3; end
         "P": begin lut_pat = 5'b01100; lut_len = 3'd4; end
         "Q": begin lut_pat = 5'b11010; lut_len = 3'd4; end
         "R": begin lut_pat = 5'b01000; lut_len = 3'd3; end
         "S": begin lut_pat = 5'b00000; lut_len = 3'd3; end
         "T": begin lut_pat = 5'b10000; lut_len = 3'd1; end
         "U": begin lut_pat = 5'b00100; lut_len = 3'd3; end
         "V": begin lut_pat = 5'b00010; lut_len = 3'd4; end
         "W": begin lut_pat = 5'b01100; lut_len = 3'd3; end
         "X": begin lut_pat = 5'b10010; lut_len = 3'd4; end
         "Y": begin lut_pat = 5'b10110; lut_len = 3'd4; end
         "Z": begin lut_pat = 5'b11000; lut_len = 3'd4; end
`ifdef MORSE_DIGITS_EN
         "0": begin lut_pat = 5'b11111; lut_len = 3'd5; end
         "1": begin lut_pat = 5'b01111; lut_len = 3'd5; end
         "2": begin lut_pat = 5'b00111; lut_len = 3'd5; end
         "3": begin lut_pat = 5'b00011; lut_len = 3'd5; end
         "4": begin lut_pat = 5'b00001; lut_len = 3'd5; end
         "5": begin lut_pat = 5'b00000; lut_len = 3'd5; end
         "6": begin lut_pat = 5'b10000; lut_len = 3'd5; end
         "7": begin lut_pat = 5'b11000; lut_len = 3'd5; end
         "8": begin lut_pat = 5'b11100; lut_len = 3'd5; end
         "9": begin lut_pat = 5'b11110; lut_len = 3'd5; end
`endif
         default: lut_hit = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      char_d  = char_q;
      pat_d   = pat_q;
      len_d   = len_q;
      gap_d   = gap_q;
      err     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (i_Char_Valid && rdy_q) begin
               char_d  = i_Char;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (lut_hit) begin
               pat_d   = lut_pat;
               len_d   = lut_len;
               state_d = S_START;
            end else if (char_q == 8'h20) begin
               gap_d   = WordLoad;
               state_d = S_GAP;
            end else begin
               err     = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (i_Done) begin
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!i_Done) begin
               gap_d   = LetterLoad;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q <= S_IDLE;
         char_q  <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         gap_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         char_q  <= char_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         gap_q   <= gap_d;
         rdy_q   <= 1'b1;
      end
   end

   // Ready is held off until the first edge after reset release
   assign o_Char_Ready    = rdy_q && (state_q == S_IDLE);
   assign o_Start         = (state_q == S_START);
   assign o_Busy          = (state_q != S_IDLE);
   assign o_Char_Error    = err;
   assign o_Morse_Pattern = pat_q;
   assign o_Morse_Length  = len_q;

endmodule
